// File: rtl/stage_memory.sv
// Memory-access stage: issues byte/half/word loads and stores over a
// req/ready handshake, aligns and extends load data, stalls upstream while
// an access is outstanding, and aborts an access that never completes.
module stage_memory #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        valid_out,
  output logic [31:0] mem_rd_data,
  output logic [31:0] mem_alu_result,
  output logic        misaligned,
  output logic        bus_error
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  // Abort fires on the last permitted REQ cycle, so REQ lasts exactly
  // TIMEOUT_CYCLES cycles before the error result appears.
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

  // Note: the reset port keeps its historical name but is active-high.
  logic        w_rst;

  state_t      r_state;
  logic [31:0] r_count;
  logic [31:0] r_alu;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_is_store;
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic [31:0] r_dmem_addr;
  logic [3:0]  r_dmem_be;
  logic [31:0] r_dmem_wdata;
  logic        r_valid_out;
  logic [31:0] r_rd_data;
  logic        r_misaligned;
  logic        r_bus_error;

  logic        w_is_mem;
  logic        w_bad_align;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;

  assign w_rst    = reset_n;
  assign w_is_mem = mem_read | mem_write;

  // Size 11 is never legal; halves need addr[0]=0, words need addr[1:0]=0.
  assign w_bad_align = (mem_size == 2'b11) ||
                       ((mem_size == 2'b01) && alu_result[0]) ||
                       ((mem_size == 2'b10) && (alu_result[1:0] != 2'b00));

  assign w_timeout = TO_EN && (r_count == TO_LAST);

  // Byte-enable pattern for the store or load being accepted.
  always_comb begin
    w_be = 4'b0000;
    case (mem_size)
      2'b00:   w_be = 4'b0001 << alu_result[1:0];
      2'b01:   w_be = alu_result[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Store data replicated across lanes so the enabled lane always carries it.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    always_comb begin
      w_wdata[8*gi +: 8] = store_data[8*gi +: 8];
      case (mem_size)
        2'b00:   w_wdata[8*gi +: 8] = store_data[7:0];
        2'b01:   w_wdata[8*gi +: 8] = store_data[8*(gi%2) +: 8];
        default: w_wdata[8*gi +: 8] = store_data[8*gi +: 8];
      endcase
    end
  end

  assign w_shifted = dmem_rdata >> {r_alu[1:0], 3'b000};

  // Extract the addressed byte/half from the read word and extend it.
  always_comb begin
    w_load_data = w_shifted;
    case (r_size)
      2'b00: w_load_data = r_unsigned ? {24'h0, w_shifted[7:0]}
                                      : {{24{w_shifted[7]}}, w_shifted[7:0]};
      2'b01: w_load_data = r_unsigned ? {16'h0, w_shifted[15:0]}
                                      : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  // Access FSM with all bus signals and result outputs registered.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_alu        <= '0;
      r_size       <= '0;
      r_unsigned   <= 1'b0;
      r_is_store   <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_be    <= '0;
      r_dmem_wdata <= '0;
      r_valid_out  <= 1'b0;
      r_rd_data    <= '0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_valid_out  <= 1'b0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid_in) begin
            r_alu      <= alu_result;
            r_size     <= mem_size;
            r_unsigned <= mem_unsigned;
            r_is_store <= mem_write;
            r_count    <= '0;
            if (!w_is_mem) begin
              r_valid_out <= 1'b1;
              r_rd_data   <= '0;
            end else if (w_bad_align) begin
              r_valid_out  <= 1'b1;
              r_misaligned <= 1'b1;
              r_rd_data    <= '0;
            end else begin
              r_state      <= S_REQ;
              r_dmem_req   <= 1'b1;
              r_dmem_we    <= mem_write;
              r_dmem_addr  <= {alu_result[31:2], 2'b00};
              r_dmem_be    <= w_be;
              r_dmem_wdata <= w_wdata;
            end
          end
        end
        S_REQ: begin
          if (dmem_ready) begin
            r_state     <= S_IDLE;
            r_dmem_req  <= 1'b0;
            r_dmem_we   <= 1'b0;
            r_valid_out <= 1'b1;
            r_rd_data   <= r_is_store ? 32'h0 : w_load_data;
          end else if (w_timeout) begin
            r_state     <= S_IDLE;
            r_dmem_req  <= 1'b0;
            r_dmem_we   <= 1'b0;
            r_valid_out <= 1'b1;
            r_bus_error <= 1'b1;
            r_rd_data   <= '0;
          end else begin
            r_count <= r_count + 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall          = (r_state == S_REQ);
  assign dmem_req       = r_dmem_req;
  assign dmem_we        = r_dmem_we;
  assign dmem_addr      = r_dmem_addr;
  assign dmem_be        = r_dmem_be;
  assign dmem_wdata     = r_dmem_wdata;
  assign valid_out      = r_valid_out;
  assign mem_rd_data    = r_rd_data;
  assign mem_alu_result = r_alu;
  assign misaligned     = r_misaligned;
  assign bus_error      = r_bus_error;

endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory with a short timeout (4 cycles).
module tb_stage_memory;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_in;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        valid_out;
  logic [31:0] mem_rd_data;
  logic [31:0] mem_alu_result;
  logic        misaligned;
  logic        bus_error;

  int n_vec = 0;
  int n_err = 0;
  int st_cyc;

  stage_memory #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .alu_result(alu_result),
    .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .valid_out(valid_out), .mem_rd_data(mem_rd_data),
    .mem_alu_result(mem_alu_result), .misaligned(misaligned), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single accept edge, then go idle.
  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] sd);
    valid_in = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz;
    mem_unsigned = uns; alu_result = addr; store_data = sd;
    step();
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Count REQ (stall) cycles, raising dmem_ready on the ready_at-th one; bounded.
  task automatic run_req(input int ready_at, input logic [31:0] rdata, output int cycles);
    cycles = 0;
    for (int c = 1; c <= 20; c++) begin
      if (!stall) break;
      cycles++;
      if (c == ready_at) begin
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
      end
      step();
      dmem_ready = 1'b0;
      dmem_rdata = 32'h0;
    end
  endtask

  task automatic check_done(input string tag, input logic [31:0] rd, input logic mis,
                            input logic berr, input logic [31:0] alu);
    check_vec({tag, ".valid"}, {31'h0, valid_out}, 32'h1);
    check_vec({tag, ".rdata"}, mem_rd_data, rd);
    check_vec({tag, ".mis"}, {31'h0, misaligned}, {31'h0, mis});
    check_vec({tag, ".berr"}, {31'h0, bus_error}, {31'h0, berr});
    check_vec({tag, ".alu"}, mem_alu_result, alu);
    check_vec({tag, ".stall"}, {31'h0, stall}, 32'h0);
    check_vec({tag, ".req"}, {31'h0, dmem_req}, 32'h0);
    $display("txn %s: valid_out=%0b rd_data=0x%08h mis=%0b berr=%0b",
             tag, valid_out, mem_rd_data, misaligned, bus_error);
    step();
    check_vec({tag, ".pulse"}, {29'h0, valid_out, misaligned, bus_error}, 32'h0);
  endtask

  task automatic check_bus(input string tag, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
    check_vec({tag, ".req"}, {31'h0, dmem_req}, 32'h1);
    check_vec({tag, ".stall"}, {31'h0, stall}, 32'h1);
    check_vec({tag, ".we"}, {31'h0, dmem_we}, {31'h0, we});
    check_vec({tag, ".addr"}, dmem_addr, addr);
    check_vec({tag, ".be"}, {28'h0, dmem_be}, {28'h0, be});
    if (we) check_vec({tag, ".wdata"}, dmem_wdata, wd);
  endtask

  initial begin
    reset_n = 1'b1; valid_in = 1'b0; alu_result = 32'h0; store_data = 32'h0;
    mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0;
    dmem_ready = 1'b0; dmem_rdata = 32'h0;
    step(); step();
    check_vec("rst.outs", {27'h0, stall, dmem_req, valid_out, misaligned, bus_error}, 32'h0);
    check_vec("rst.rdata", mem_rd_data, 32'h0);
    check_vec("rst.alu", mem_alu_result, 32'h0);
    check_vec("rst.addr", dmem_addr, 32'h0);
    reset_n = 1'b0;
    step();

    // Non-memory pass-through.
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h1F4, 32'h0);
    check_done("nonmem", 32'h0, 1'b0, 1'b0, 32'h1F4);

    // SB at 0x103, ready on the third REQ cycle.
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 32'hAABBCCDD);
    check_bus("sb", 1'b1, 32'h100, 4'b1000, 32'hDDDDDDDD);
    run_req(3, 32'h0, st_cyc);
    check_vec("sb.stallcyc", st_cyc, 32'd3);
    check_done("sb", 32'h0, 1'b0, 1'b0, 32'h103);

    // SH at 0x102 and SW at 0x100.
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h12345678);
    check_bus("sh", 1'b1, 32'h100, 4'b1100, 32'h56785678);
    run_req(1, 32'h0, st_cyc);
    check_done("sh", 32'h0, 1'b0, 1'b0, 32'h102);
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h89ABCDEF);
    check_bus("sw", 1'b1, 32'h100, 4'b1111, 32'h89ABCDEF);
    run_req(1, 32'h0, st_cyc);
    check_done("sw", 32'h0, 1'b0, 1'b0, 32'h100);

    // Read and write both set: the store wins.
    issue(1'b1, 1'b1, 2'b00, 1'b0, 32'h041, 32'h000000A5);
    check_bus("rdwr", 1'b1, 32'h040, 4'b0010, 32'hA5A5A5A5);
    run_req(1, 32'hFFFFFFFF, st_cyc);
    check_done("rdwr", 32'h0, 1'b0, 1'b0, 32'h041);

    // LB / LBU at 0x102.
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h102, 32'h0);
    check_bus("lb", 1'b0, 32'h100, 4'b0100, 32'h0);
    run_req(1, 32'h00800000, st_cyc);
    check_vec("lb.stallcyc", st_cyc, 32'd1);
    check_done("lb", 32'hFFFFFF80, 1'b0, 1'b0, 32'h102);
    issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h102, 32'h0);
    run_req(1, 32'h00800000, st_cyc);
    check_done("lbu", 32'h00000080, 1'b0, 1'b0, 32'h102);

    // Misaligned word, then LH / LHU at 0x102.
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
    check_done("lw_mis", 32'h0, 1'b1, 1'b0, 32'h102);
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
    check_bus("lh", 1'b0, 32'h100, 4'b1100, 32'h0);
    run_req(1, 32'h80010000, st_cyc);
    check_done("lh", 32'hFFFF8001, 1'b0, 1'b0, 32'h102);
    issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
    run_req(1, 32'h80010000, st_cyc);
    check_done("lhu", 32'h00008001, 1'b0, 1'b0, 32'h102);

    // Odd halfword address and illegal size 11 are rejected.
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h201, 32'h0);
    check_done("sh_mis", 32'h0, 1'b1, 1'b0, 32'h201);
    issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h200, 32'h0);
    check_done("sz11", 32'h0, 1'b1, 1'b0, 32'h200);

    // No ready: abort after 4 REQ cycles.
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    run_req(0, 32'h0, st_cyc);
    check_vec("to.stallcyc", st_cyc, 32'd4);
    check_done("timeout", 32'h0, 1'b0, 1'b1, 32'h200);

    // Ready on the last allowed cycle beats the timeout.
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h204, 32'h0);
    run_req(4, 32'hCAFEBABE, st_cyc);
    check_vec("rdy4.stallcyc", st_cyc, 32'd4);
    check_done("rdy_vs_to", 32'hCAFEBABE, 1'b0, 1'b0, 32'h204);

    // Reset during the second REQ cycle, late ready ignored, then normal op.
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    step();
    check_vec("rstreq.stall", {31'h0, stall}, 32'h1);
    reset_n = 1'b1;
    step();
    reset_n = 1'b0;
    check_vec("rstreq.outs", {29'h0, stall, dmem_req, valid_out}, 32'h0);
    dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF;
    step();
    dmem_ready = 1'b0;
    check_vec("rstreq.late", {29'h0, stall, dmem_req, valid_out}, 32'h0);
    $display("txn rst_in_req: stall=%0b req=%0b valid_out=%0b", stall, dmem_req, valid_out);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h304, 32'h0);
    check_bus("after_rst", 1'b0, 32'h304, 4'b1111, 32'h0);
    run_req(1, 32'h11223344, st_cyc);
    check_done("after_rst", 32'h11223344, 1'b0, 1'b0, 32'h304);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
